// File: rtl/audio_pkg.sv
// Shared audio-path constants and the gain stage state encoding.
package audio_pkg;

    localparam int unsigned SAMPLE_W  = 24;
    localparam int unsigned AXIS_W    = 32;
    localparam int unsigned GAIN_FRAC = 14;
    localparam logic [15:0] GAIN_ONE  = 16'h4000;

    typedef enum logic [2:0] {
        RX_L,
        RX_R,
        CALC,
        TX_L,
        TX_R
    } gain_state_t;

endpackage

// File: rtl/gain_mul_sat.sv
// Signed sample times unsigned Q2.14 gain, rounded half up and saturated back to sample width.
module gain_mul_sat #(
    parameter int unsigned SAMPLE_W = 24,
    parameter int unsigned GAIN_W   = 16
) (
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic [GAIN_W-1:0]   gain_i,
    output logic [SAMPLE_W-1:0] result_o,
    output logic                clip_o
);
    import audio_pkg::*;

    localparam int unsigned PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam int unsigned HI_W   = PROD_W - SAMPLE_W + 1;

    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod_rnd;
    logic signed [PROD_W-1:0] q;
    logic        [HI_W-1:0]   q_hi;

    assign sample_ext = $signed({{(PROD_W-SAMPLE_W){sample_i[SAMPLE_W-1]}}, sample_i});
    assign gain_ext   = $signed({{(PROD_W-GAIN_W){1'b0}}, gain_i});
    assign prod       = sample_ext * gain_ext;
    assign prod_rnd   = prod + $signed(PROD_W'(1) <<< (GAIN_FRAC - 1));
    assign q          = prod_rnd >>> GAIN_FRAC;

    // Result fits only if every bit above the sample MSB matches the sign bit.
    assign q_hi   = q[PROD_W-1:SAMPLE_W-1];
    assign clip_o = !((&q_hi) || !(|q_hi));

    always_comb begin
        result_o = q[SAMPLE_W-1:0];
        if (clip_o) begin
            result_o = q[PROD_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                   : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/axis_stereo_gain.sv
// AXIS stereo gain stage: collects an L/R frame, applies per-frame ramped gain, replays the frame.
module axis_stereo_gain #(
    parameter int unsigned       SAMPLE_W  = 24,
    parameter int unsigned       GAIN_W    = 16,
    parameter logic [GAIN_W-1:0] RAMP_STEP = GAIN_W'(16)
) (
    input  logic                        axis_clk,
    input  logic                        axis_reset,
    input  logic [audio_pkg::AXIS_W-1:0] s_axis_data,
    input  logic                        s_axis_valid,
    output logic                        s_axis_ready,
    input  logic                        s_axis_last,
    output logic [audio_pkg::AXIS_W-1:0] m_axis_data,
    output logic                        m_axis_valid,
    input  logic                        m_axis_ready,
    output logic                        m_axis_last,
    input  logic [GAIN_W-1:0]           gain_l,
    input  logic [GAIN_W-1:0]           gain_r,
    input  logic                        mute,
    output logic                        clip_l,
    output logic                        clip_r
);
    import audio_pkg::*;

    localparam int unsigned PAD_W = AXIS_W - SAMPLE_W;

    gain_state_t         state_q;
    logic [SAMPLE_W-1:0] l_q;
    logic [SAMPLE_W-1:0] r_q;
    logic [SAMPLE_W-1:0] out_r_q;
    logic [GAIN_W-1:0]   cur_l_q;
    logic [GAIN_W-1:0]   cur_r_q;
    logic [AXIS_W-1:0]   m_data_q;
    logic                m_valid_q;
    logic                m_last_q;
    logic                s_ready_q;
    logic                clip_l_q;
    logic                clip_r_q;

    logic [SAMPLE_W-1:0] mul_l_c;
    logic [SAMPLE_W-1:0] mul_r_c;
    logic                sat_l_c;
    logic                sat_r_c;
    logic [GAIN_W-1:0]   tgt_l_c;
    logic [GAIN_W-1:0]   tgt_r_c;
    logic                s_fire_c;
    logic                unused_c;

    assign unused_c = ^s_axis_data[AXIS_W-1:SAMPLE_W];
    assign s_fire_c = s_axis_valid && s_ready_q;
    assign tgt_l_c  = mute ? '0 : gain_l;
    assign tgt_r_c  = mute ? '0 : gain_r;

    // Move cur toward tgt by at most RAMP_STEP.
    function automatic logic [GAIN_W-1:0] ramp_next(input logic [GAIN_W-1:0] cur,
                                                     input logic [GAIN_W-1:0] tgt);
        if (tgt > cur) begin
            return ((tgt - cur) > RAMP_STEP) ? cur + RAMP_STEP : tgt;
        end
        return ((cur - tgt) > RAMP_STEP) ? cur - RAMP_STEP : tgt;
    endfunction

    gain_mul_sat #(.SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W)) u_mul_l (
        .sample_i (l_q),
        .gain_i   (cur_l_q),
        .result_o (mul_l_c),
        .clip_o   (sat_l_c)
    );

    gain_mul_sat #(.SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W)) u_mul_r (
        .sample_i (r_q),
        .gain_i   (cur_r_q),
        .result_o (mul_r_c),
        .clip_o   (sat_r_c)
    );

    always_ff @(posedge axis_clk) begin
        if (axis_reset) begin
            state_q   <= RX_L;
            l_q       <= '0;
            r_q       <= '0;
            out_r_q   <= '0;
            cur_l_q   <= '0;
            cur_r_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            s_ready_q <= 1'b0;
            clip_l_q  <= 1'b0;
            clip_r_q  <= 1'b0;
        end else begin
            clip_l_q <= 1'b0;
            clip_r_q <= 1'b0;
            case (state_q)
                RX_L: begin
                    s_ready_q <= 1'b1;
                    if (s_fire_c && !s_axis_last) begin
                        l_q     <= s_axis_data[SAMPLE_W-1:0];
                        state_q <= RX_R;
                    end
                end
                RX_R: begin
                    if (s_fire_c) begin
                        if (s_axis_last) begin
                            r_q       <= s_axis_data[SAMPLE_W-1:0];
                            s_ready_q <= 1'b0;
                            state_q   <= CALC;
                        end else begin
                            l_q <= s_axis_data[SAMPLE_W-1:0];
                        end
                    end
                end
                CALC: begin
                    m_data_q  <= {{PAD_W{1'b0}}, mul_l_c};
                    out_r_q   <= mul_r_c;
                    m_valid_q <= 1'b1;
                    m_last_q  <= 1'b0;
                    clip_l_q  <= sat_l_c;
                    clip_r_q  <= sat_r_c;
                    cur_l_q   <= ramp_next(cur_l_q, tgt_l_c);
                    cur_r_q   <= ramp_next(cur_r_q, tgt_r_c);
                    state_q   <= TX_L;
                end
                TX_L: begin
                    if (m_axis_ready) begin
                        m_data_q <= {{PAD_W{1'b0}}, out_r_q};
                        m_last_q <= 1'b1;
                        state_q  <= TX_R;
                    end
                end
                TX_R: begin
                    if (m_axis_ready) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        s_ready_q <= 1'b1;
                        state_q   <= RX_L;
                    end
                end
                default: begin
                    s_ready_q <= 1'b0;
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                    state_q   <= RX_L;
                end
            endcase
        end
    end

    assign s_axis_ready = s_ready_q;
    assign m_axis_data  = m_data_q;
    assign m_axis_valid = m_valid_q;
    assign m_axis_last  = m_last_q;
    assign clip_l       = clip_l_q;
    assign clip_r       = clip_r_q;

endmodule

// File: tb/tb_axis_stereo_gain.sv
// Bench for axis_stereo_gain: frame-level reference model with ramped gains and saturating arithmetic.
module tb_axis_stereo_gain;

    localparam int STEP = 'h1000;

    logic        clk;
    logic        axis_reset;
    logic [31:0] s_axis_data;
    logic        s_axis_valid;
    logic        s_axis_ready;
    logic        s_axis_last;
    logic [31:0] m_axis_data;
    logic        m_axis_valid;
    logic        m_axis_ready;
    logic        m_axis_last;
    logic [15:0] gain_l;
    logic [15:0] gain_r;
    logic        mute;
    logic        clip_l;
    logic        clip_r;

    int total;
    int bad;
    int cur_l;
    int cur_r;
    logic [23:0] obs_l;
    logic [23:0] obs_r;

    axis_stereo_gain #(.SAMPLE_W(24), .GAIN_W(16), .RAMP_STEP(16'h1000)) dut (
        .axis_clk     (clk),
        .axis_reset   (axis_reset),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .s_axis_last  (s_axis_last),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_last  (m_axis_last),
        .gain_l       (gain_l),
        .gain_r       (gain_r),
        .mute         (mute),
        .clip_l       (clip_l),
        .clip_r       (clip_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ramp(input int cur, input int tgt);
        if (tgt > cur) return (cur + STEP < tgt) ? cur + STEP : tgt;
        return (cur - STEP > tgt) ? cur - STEP : tgt;
    endfunction

    // Exact product, floor((p + 2^13) / 2^14), then clamp to the 24-bit signed range.
    function automatic logic [23:0] ref_gain(input logic [23:0] s, input int g, output logic clip);
        longint p;
        longint q;
        p = longint'($signed(s)) * longint'(g);
        q = (p + 64'sd8192) >>> 14;
        clip = 1'b1;
        if (q > 64'sd8388607) return 24'h7FFFFF;
        if (q < -64'sd8388608) return 24'h800000;
        clip = 1'b0;
        return q[23:0];
    endfunction

    task automatic send_beat(input logic [23:0] d, input logic last);
        int n;
        s_axis_data  = {8'($urandom), d};
        s_axis_last  = last;
        s_axis_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axis_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!s_axis_ready) begin
            total++;
            bad++;
            $display("FAIL beat_accept: s_axis_ready got %b want 1 within 50 cycles", s_axis_ready);
        end
        @(posedge clk);
        #1;
        s_axis_valid = 1'b0;
    endtask

    task automatic recv_frame(input logic [23:0] l, input logic [23:0] r);
        logic [23:0] el;
        logic [23:0] er;
        logic cl;
        logic cr;
        int n;
        el = ref_gain(l, cur_l, cl);
        er = ref_gain(r, cur_r, cr);
        cur_l = ramp(cur_l, mute ? 0 : int'(gain_l));
        cur_r = ramp(cur_r, mute ? 0 : int'(gain_r));
        m_axis_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!m_axis_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL frame_latency: cycles got %0d want 1 (valid=%b)", n, m_axis_valid);
            return;
        end
        obs_l = m_axis_data[23:0];
        total++;
        if ({m_axis_data, m_axis_last, clip_l, clip_r, s_axis_ready} !== {8'h00, el, 1'b0, cl, cr, 1'b0}) begin
            bad++;
            $display("FAIL left_beat: data/last/clip_l/clip_r/s_ready got %h/%b/%b/%b/%b want %h/0/%b/%b/0",
                     m_axis_data, m_axis_last, clip_l, clip_r, s_axis_ready, {8'h00, el}, cl, cr);
        end
        @(negedge clk);
        obs_r = m_axis_data[23:0];
        total++;
        if ({m_axis_valid, m_axis_data, m_axis_last, clip_l, clip_r} !== {1'b1, 8'h00, er, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL right_beat: valid/data/last/clip_l/clip_r got %b/%h/%b/%b/%b want 1/%h/1/0/0",
                     m_axis_valid, m_axis_data, m_axis_last, clip_l, clip_r, {8'h00, er});
        end
        @(negedge clk);
        total++;
        if (m_axis_valid !== 1'b0) begin
            bad++;
            $display("FAIL frame_end: m_axis_valid got %b want 0", m_axis_valid);
        end
    endtask

    task automatic frame(input logic [23:0] l, input logic [23:0] r);
        send_beat(l, 1'b0);
        send_beat(r, 1'b1);
        recv_frame(l, r);
    endtask

    task automatic settle(input int n);
        repeat (n) frame(24'($urandom), 24'($urandom));
    endtask

    task automatic test_reset();
        axis_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({s_axis_ready, m_axis_valid, m_axis_last, m_axis_data, clip_l, clip_r} !== 37'd0) begin
            bad++;
            $display("FAIL reset_outputs: ready/valid/last/data/clip got %b/%b/%b/%h/%b%b want all zero",
                     s_axis_ready, m_axis_valid, m_axis_last, m_axis_data, clip_l, clip_r);
        end
        axis_reset = 1'b0;
        cur_l = 0;
        cur_r = 0;
        @(negedge clk);
        total++;
        if (s_axis_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_after_release: s_axis_ready got %b want 0", s_axis_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (s_axis_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_rise: s_axis_ready got %b want 1", s_axis_ready);
        end
    endtask

    task automatic test_ramp_mute();
        logic [23:0] up [5];
        logic [23:0] down [5];
        up   = '{24'h0, 24'h400, 24'h800, 24'hC00, 24'h1000};
        down = '{24'h1000, 24'hC00, 24'h800, 24'h400, 24'h0};
        gain_l = 16'h4000;
        gain_r = 16'h4000;
        mute = 1'b0;
        for (int i = 0; i < 5; i++) begin
            frame(24'h001000, 24'h001000);
            total++;
            if (obs_l !== up[i] || obs_r !== up[i]) begin
                bad++;
                $display("FAIL ramp_up[%0d]: L/R got %h/%h want %h", i, obs_l, obs_r, up[i]);
            end
        end
        mute = 1'b1;
        for (int i = 0; i < 5; i++) begin
            frame(24'h001000, 24'h001000);
            total++;
            if (obs_l !== down[i] || obs_r !== down[i]) begin
                bad++;
                $display("FAIL mute_down[%0d]: L/R got %h/%h want %h", i, obs_l, obs_r, down[i]);
            end
        end
        mute = 1'b0;
    endtask

    task automatic test_unity();
        gain_l = 16'h4000;
        gain_r = 16'h4000;
        settle(4);
        frame(24'h000100, 24'hFFFF00);
        total++;
        if (obs_l !== 24'h000100 || obs_r !== 24'hFFFF00) begin
            bad++;
            $display("FAIL unity: L/R got %h/%h want 000100/ffff00", obs_l, obs_r);
        end
    endtask

    task automatic test_saturation();
        gain_l = 16'h8000;
        gain_r = 16'h8000;
        settle(4);
        frame(24'h500000, 24'hA00000);
        total++;
        if (obs_l !== 24'h7FFFFF || obs_r !== 24'h800000) begin
            bad++;
            $display("FAIL saturation: L/R got %h/%h want 7fffff/800000", obs_l, obs_r);
        end
    endtask

    task automatic test_rounding();
        gain_l = 16'h2000;
        gain_r = 16'h2000;
        settle(6);
        frame(24'h000003, 24'hFFFFFD);
        total++;
        if (obs_l !== 24'h000002 || obs_r !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL rounding: L/R got %h/%h want 000002/ffffff", obs_l, obs_r);
        end
    endtask

    task automatic test_resync();
        logic [23:0] l1;
        logic [23:0] l2;
        logic [23:0] r;
        int seen;
        l1 = 24'($urandom);
        l2 = 24'($urandom);
        r  = 24'($urandom);
        send_beat(24'h123456, 1'b1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (m_axis_valid) seen++;
        end
        total++;
        if (seen != 0 || s_axis_ready !== 1'b1) begin
            bad++;
            $display("FAIL lone_right_dropped: valid cycles got %0d ready %b want 0 and 1", seen, s_axis_ready);
        end
        send_beat(l1, 1'b0);
        send_beat(l2, 1'b0);
        send_beat(r, 1'b1);
        recv_frame(l2, r);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            gain_l = 16'($urandom);
            gain_r = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            mute   = ($urandom_range(0, 5) == 0);
            frame(24'($urandom), 24'($urandom));
        end
        mute = 1'b0;
    endtask

    task automatic test_back_to_back_reset();
        logic [23:0] el;
        logic [23:0] er;
        logic cl;
        logic cr;
        int n;
        gain_l = 16'h4000;
        gain_r = 16'h3000;
        m_axis_ready = 1'b0;
        send_beat(24'h0ABCDE, 1'b0);
        send_beat(24'hF12345, 1'b1);
        el = ref_gain(24'h0ABCDE, cur_l, cl);
        er = ref_gain(24'hF12345, cur_r, cr);
        n = 0;
        @(negedge clk);
        while (!m_axis_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({m_axis_valid, m_axis_data, m_axis_last, s_axis_ready} !== {1'b1, 8'h00, el, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL hold_left[%0d]: valid/data/last/ready got %b/%h/%b/%b want 1/%h/0/0",
                         i, m_axis_valid, m_axis_data, m_axis_last, s_axis_ready, {8'h00, el});
            end
            @(negedge clk);
        end
        m_axis_ready = 1'b1;
        @(posedge clk);
        #1;
        m_axis_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({m_axis_valid, m_axis_data, m_axis_last} !== {1'b1, 8'h00, er, 1'b1}) begin
            bad++;
            $display("FAIL hold_right: valid/data/last got %b/%h/%b want 1/%h/1",
                     m_axis_valid, m_axis_data, m_axis_last, {8'h00, er});
        end
        axis_reset = 1'b1;
        @(posedge clk);
        #1;
        axis_reset = 1'b0;
        cur_l = 0;
        cur_r = 0;
        @(negedge clk);
        total++;
        if ({m_axis_valid, m_axis_last, m_axis_data, s_axis_ready, clip_l, clip_r} !== 37'd0) begin
            bad++;
            $display("FAIL reset_in_tx: valid/last/data/ready/clip got %b/%b/%h/%b/%b%b want all zero",
                     m_axis_valid, m_axis_last, m_axis_data, s_axis_ready, clip_l, clip_r);
        end
        frame(24'h400000, 24'h400000);
        total++;
        if (obs_l !== 24'h0 || obs_r !== 24'h0) begin
            bad++;
            $display("FAIL gains_cleared: L/R got %h/%h want 000000/000000", obs_l, obs_r);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation time got %0t want completion", $time);
        $fatal(1);
    end

    initial begin
        total = 0;
        bad = 0;
        cur_l = 0;
        cur_r = 0;
        axis_reset = 1'b1;
        s_axis_data = '0;
        s_axis_valid = 1'b0;
        s_axis_last = 1'b0;
        m_axis_ready = 1'b0;
        gain_l = '0;
        gain_r = '0;
        mute = 1'b0;
        test_reset();
        test_ramp_mute();
        test_unity();
        test_saturation();
        test_rounding();
        test_resync();
        test_random();
        test_back_to_back_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
